// File: rtl/uart_mem_loader_pkg.sv
// uart_mem_loader_pkg: loader FSM states and sticky error codes
package uart_mem_loader_pkg;
  typedef enum logic [2:0] {IDLE, CHAN, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_HDR, ERR_CSUM, ERR_TMO} err_t;
endpackage

// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: shared write bus toward the target memories
interface uart_mem_loader_if #(
  parameter int CHANNELS = 2,
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [CHANNELS-1:0] wr_en;
  modport master (output wr_addr, wr_data, wr_en);
  modport slave (input wr_addr, wr_data, wr_en);
endinterface

// File: rtl/uart_mem_loader_rx_strobe_sync.sv
// uart_mem_loader_rx_strobe_sync: 2-FF synchroniser, rising-edge strobe and byte capture
module uart_mem_loader_rx_strobe_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_ready,
  output logic       stb,
  output logic [7:0] data
);
  logic [2:0] sync;
  // Byte is grabbed one edge before the strobe so it is ready when the strobe fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      data <= '0;
    end else begin
      sync <= {sync[1:0], rx_ready};
      if (sync[0] && !sync[1]) data <= rx_byte;
    end
  end
  assign stb = sync[1] && !sync[2];
endmodule

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: framed UART packet decoder writing payloads into one of CHANNELS memories
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ADDR_W = 14,
  parameter int TIMEOUT = 1000000,
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_byte,
  input  logic               rx_ready,
  uart_mem_loader_if.master  wr,
  output logic               hold,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);
  state_t state, next;
  err_t code, err_q;
  logic stb, active;
  logic [7:0] data, len_lo, csum, wdata;
  logic [16:0] len_new, cnt;
  logic [CW-1:0] ch;
  logic [TW-1:0] tmo;
  logic [ADDR_W-1:0] addr;
  logic [CHANNELS-1:0] wen;
  uart_mem_loader_rx_strobe_sync u_sync (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_ready(rx_ready), .stb(stb), .data(data)
  );
  assign len_new = {1'b0, data, len_lo};
  assign active = state inside {CHAN, LEN_LO, LEN_HI, DATA, CSUM};
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    code = state == CSUM ? ERR_CSUM : ERR_HDR;
    case (state)
      IDLE:    next = stb && data == MAGIC ? CHAN : IDLE;
      CHAN:    next = !stb ? CHAN : data >= 8'(CHANNELS) ? ERR : LEN_LO;
      LEN_LO:  next = stb ? LEN_HI : LEN_LO;
      LEN_HI:  next = !stb ? LEN_HI : len_new > MAX_LEN ? ERR : len_new == '0 ? CSUM : DATA;
      DATA:    next = stb && cnt == 17'd1 ? CSUM : DATA;
      CSUM:    next = !stb ? CSUM : data == csum ? DONE : ERR;
      default: next = IDLE;
    endcase
    if (active && !stb && tmo == TW'(TIMEOUT - 1)) begin
      next = ERR;
      code = ERR_TMO;
    end
  end
  // Address advances after each write except the last, so a full frame parks on the top address.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen <= '0;
      wdata <= '0;
      addr <= '0;
      hold <= 1'b0;
      err_q <= ERR_NONE;
      csum <= '0;
      cnt <= '0;
      ch <= '0;
      len_lo <= '0;
      tmo <= '0;
    end else begin
      wen <= '0;
      tmo <= active && !stb ? tmo + 1'b1 : '0;
      if (|wen && cnt != '0) addr <= addr + 1'b1;
      if (next == ERR) err_q <= code;
      if (next == DONE) hold <= 1'b0;
      if (stb)
        case (state)
          IDLE: if (data == MAGIC) begin
            hold <= 1'b1;
            err_q <= ERR_NONE;
            csum <= '0;
          end
          CHAN: ch <= data[CW-1:0];
          LEN_LO: len_lo <= data;
          LEN_HI: begin
            addr <= '0;
            cnt <= len_new;
          end
          DATA: begin
            wdata <= data;
            wen <= CHANNELS'(1) << ch;
            csum <= csum + data;
            cnt <= cnt - 1'b1;
          end
          default: ;
        endcase
    end
  end
  assign wr.wr_addr = addr;
  assign wr.wr_data = wdata;
  assign wr.wr_en = wen;
  assign busy = active;
  assign done = state == DONE;
  assign err = err_q;
endmodule
